// File: rtl/jkb_pkg.sv
// Shared encodings for the JK flip-flop bank.
// Holds the {J,K} operation codes and the MODE select values.
package jkb_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TOG  = 2'b11
    } jk_op_e;

    localparam logic MODE_JK  = 1'b0;
    localparam logic MODE_CNT = 1'b1;

endpackage

// File: rtl/jk_ff_bank_cell.sv
// One master-slave JK channel (module jk_cell).
// The master loads on the CLK rising edge and the slave on the falling edge.
// Asynchronous preset and clear are active-low. A force-toggle input is included.
module jk_cell
    import jkb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    input  logic ftog,
    input  logic en,
    input  logic pre_n,
    input  logic clr_n,
    output logic q
);

    logic   m;
    jk_op_e op;

    assign op = jk_op_e'({j, k});

    // Master is edge-sampled only, so J/K activity while CLK is high is ignored.
    always_ff @(posedge clk or posedge rst or negedge pre_n or negedge clr_n) begin
        if (rst) begin
            m <= 1'b0;
        end else if (!pre_n) begin
            m <= 1'b1;
        end else if (!clr_n) begin
            m <= 1'b0;
        end else if (en) begin
            if (ftog) begin
                m <= ~q;
            end else begin
                case (op)
                    JK_HOLD: m <= q;
                    JK_RST:  m <= 1'b0;
                    JK_SET:  m <= 1'b1;
                    JK_TOG:  m <= ~q;
                    default: m <= q;
                endcase
            end
        end
    end

    always_ff @(negedge clk or posedge rst or negedge pre_n or negedge clr_n) begin
        if (rst) begin
            q <= 1'b0;
        end else if (!pre_n) begin
            q <= 1'b1;
        end else if (!clr_n) begin
            q <= 1'b0;
        end else begin
            q <= m;
        end
    end

endmodule

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH master-slave JK channels.
// With JKB_COUNTER_EN defined, a MODE port, a TC port and a ripple-carry counter mode are added.
module jk_ff_bank
    import jkb_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] PRE_N,
    input  logic [WIDTH-1:0] CLR_N,
    input  logic             EN,
`ifdef JKB_COUNTER_EN
    input  logic             MODE,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN
`ifdef JKB_COUNTER_EN
    ,
    output logic             TC
`endif
);

    logic [WIDTH-1:0]     cell_j;
    logic [WIDTH-1:0]     cell_k;
    logic [CNT_WIDTH-1:0] ftog;

`ifdef JKB_COUNTER_EN
    logic cnt_mode;

    assign cnt_mode = (MODE == MODE_CNT);

    // In counter mode, J/K are held at 00 so that a channel keeps its value
    // unless it is in the carry chain.
    always_comb begin
        logic carry;
        carry = 1'b1;
        ftog  = '0;
        for (int unsigned i = 0; i < CNT_WIDTH; i++) begin
            ftog[i] = cnt_mode & carry;
            carry   = carry & Q[i];
        end
    end

    assign cell_j = cnt_mode ? '0 : J;
    assign cell_k = cnt_mode ? '0 : K;
    assign TC     = cnt_mode & EN & (&Q);
`else
    assign ftog   = '0;
    assign cell_j = J;
    assign cell_k = K;
`endif

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk   (CLK),
            .rst   (RST),
            .j     (cell_j[g]),
            .k     (cell_k[g]),
            .ftog  (ftog[g]),
            .en    (EN),
            .pre_n (PRE_N[g]),
            .clr_n (CLR_N[g]),
            .q     (Q[g])
        );
    end

    assign QN = ~Q;

endmodule
